// File: rtl/tnoc_pkg.sv
// Shared NoC definitions: configuration record, port typing and port-index helpers.
package tnoc_pkg;

   localparam int TNOC_PORTS = 5;

   typedef logic [2:0] tnoc_port_index_t;

   typedef enum logic [2:0] {
      TNOC_LOCAL_PORT   = 3'd0,
      TNOC_X_PLUS_PORT  = 3'd1,
      TNOC_X_MINUS_PORT = 3'd2,
      TNOC_Y_PLUS_PORT  = 3'd3,
      TNOC_Y_MINUS_PORT = 3'd4
   } tnoc_port_type;

   typedef struct packed {
      int unsigned num_ports;
      int unsigned data_width;
   } tnoc_config;

   localparam tnoc_config TNOC_DEFAULT_CONFIG = '{num_ports: 32'd5, data_width: 32'd32};

   // Rotate a port index forward by one, wrapping 4 -> 0.
   function automatic tnoc_port_index_t tnoc_next_port(input tnoc_port_index_t idx);
      tnoc_port_index_t nxt;
      if (idx >= tnoc_port_index_t'(TNOC_PORTS - 1)) begin
         nxt = 3'd0;
      end else begin
         nxt = idx + 3'd1;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/tnoc_output_arbiter_checker.sv
// Protocol checks for tnoc_output_arbiter observed at its ports.
module tnoc_output_arbiter_checker
   import tnoc_pkg::*;
(
   input logic                  clk,
   input logic                  rst,
   input logic                  i_output_free,
   input logic                  i_tail,
   input logic [TNOC_PORTS-1:0] o_output_grant,
   input logic                  o_busy
);

   a_grant_onehot0: assert property (@(posedge clk) disable iff (rst)
      $onehot0(o_output_grant));

   a_busy_matches_grant: assert property (@(posedge clk) disable iff (rst)
      o_busy == (o_output_grant != '0));

   a_grant_held: assert property (@(posedge clk) disable iff (rst)
      (o_busy && !(i_output_free && i_tail)) |=> $stable(o_output_grant));

endmodule

// File: rtl/tnoc_round_robin_select.sv
// Combinational round-robin pick: first requester at or after the pointer, modulo the port count.
module tnoc_round_robin_select
   import tnoc_pkg::*;
(
   input  logic [TNOC_PORTS-1:0] i_request,
   input  tnoc_port_index_t      i_ptr,
   output logic [TNOC_PORTS-1:0] o_select,
   output tnoc_port_index_t      o_index,
   output logic                  o_valid
);

   logic [3:0]       sum_s;
   tnoc_port_index_t cand_s;

   // Scan ports in order ptr, ptr+1, ... and keep the first hit.
   always_comb begin
      o_select = '0;
      o_index  = 3'd0;
      o_valid  = 1'b0;
      sum_s    = 4'd0;
      cand_s   = 3'd0;
      for (int off = 0; off < TNOC_PORTS; off++) begin
         sum_s = {1'b0, i_ptr} + 4'(off);
         if (sum_s >= 4'(TNOC_PORTS)) begin
            cand_s = 3'(sum_s - 4'(TNOC_PORTS));
         end else begin
            cand_s = sum_s[2:0];
         end
         if (!o_valid && i_request[cand_s]) begin
            o_valid          = 1'b1;
            o_index          = cand_s;
            o_select[cand_s] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/tnoc_output_arbiter.sv
// Packet-granular round-robin arbiter for one router output port; the grant is held
// from head flit to tail flit and re-arbitrated on the tail edge without a bubble.
module tnoc_output_arbiter
   import tnoc_pkg::*;
#(
   parameter tnoc_config    CONFIG    = TNOC_DEFAULT_CONFIG,
   parameter tnoc_port_type PORT_TYPE = TNOC_LOCAL_PORT,
   parameter int            ENTRIES   = 5
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [TNOC_PORTS-1:0] i_request,
   input  logic                  i_output_free,
   input  logic                  i_tail,
   output logic [TNOC_PORTS-1:0] o_output_grant,
   output logic                  o_busy
);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   localparam bit CFG_OK = (ENTRIES == TNOC_PORTS) &&
                           (CONFIG.num_ports == 32'(ENTRIES)) &&
                           (int'(PORT_TYPE) < TNOC_PORTS);

   generate
      if (!CFG_OK) begin : g_bad_cfg
         $error("tnoc_output_arbiter: unsupported configuration");
      end
   endgenerate

   state_t                state_q, state_d;
   logic [TNOC_PORTS-1:0] grant_q, grant_d;
   tnoc_port_index_t      ptr_q, ptr_d;

   logic [TNOC_PORTS-1:0] sel_s;
   tnoc_port_index_t      sel_index_s;
   logic                  sel_valid_s;

   tnoc_round_robin_select u_select (
      .i_request (i_request),
      .i_ptr     (ptr_q),
      .o_select  (sel_s),
      .o_index   (sel_index_s),
      .o_valid   (sel_valid_s)
   );

   // Next-state logic: grant loads in IDLE or on tail acceptance, otherwise holds.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      case (state_q)
         IDLE: begin
            if (sel_valid_s) begin
               state_d = BUSY;
               grant_d = sel_s;
               ptr_d   = tnoc_next_port(sel_index_s);
            end else begin
               state_d = IDLE;
            end
         end
         BUSY: begin
            // Requester drops mid-packet are deliberately ignored; only the tail releases.
            if (i_output_free && i_tail) begin
               if (sel_valid_s) begin
                  state_d = BUSY;
                  grant_d = sel_s;
                  ptr_d   = tnoc_next_port(sel_index_s);
               end else begin
                  state_d = IDLE;
                  grant_d = '0;
               end
            end else begin
               state_d = BUSY;
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
            ptr_d   = 3'd0;
         end
      endcase
   end

   // State, grant and pointer registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         grant_q <= '0;
         ptr_q   <= 3'd0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
      end
   end

   assign o_output_grant = grant_q;
   assign o_busy         = (state_q == BUSY);

endmodule

// File: tb/tb_tnoc_output_arbiter.sv
// Directed bench for tnoc_output_arbiter with hand-computed expected grants.
module tb_tnoc_output_arbiter;
   import tnoc_pkg::*;

   logic       clk;
   logic       rst;
   logic [4:0] i_request;
   logic       i_output_free;
   logic       i_tail;
   logic [4:0] o_output_grant;
   logic       o_busy;

   int checks;
   int errors;

   tnoc_output_arbiter dut (
      .clk            (clk),
      .rst            (rst),
      .i_request      (i_request),
      .i_output_free  (i_output_free),
      .i_tail         (i_tail),
      .o_output_grant (o_output_grant),
      .o_busy         (o_busy)
   );

   tnoc_output_arbiter_checker u_chk (
      .clk            (clk),
      .rst            (rst),
      .i_output_free  (i_output_free),
      .i_tail         (i_tail),
      .o_output_grant (o_output_grant),
      .o_busy         (o_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_state(input string tag, input logic [4:0] g, input logic b, input logic [2:0] p);
      chk({tag, "_grant"}, 8'(o_output_grant), 8'(g));
      chk({tag, "_busy"}, 8'(o_busy), 8'(b));
      chk({tag, "_ptr"}, 8'(dut.ptr_q), 8'(p));
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      i_request = 5'b00000;
      i_output_free = 1'b0;
      i_tail = 1'b0;
      #2;
      chk_state("reset", 5'b00000, 1'b0, 3'd0);
      tick();
      rst = 1'b0;

      // single requester on port 2
      i_request = 5'b00100;
      tick();
      chk_state("first_grant", 5'b00100, 1'b1, 3'd3);

      // 3-flit packet with other requesters waiting
      i_request = 5'b10011;
      i_output_free = 1'b1;
      tick();
      chk("body1_grant", 8'(o_output_grant), 8'h04);
      tick();
      chk("body2_grant", 8'(o_output_grant), 8'h04);
      i_tail = 1'b1;
      tick();
      chk_state("b2b_grant", 5'b10000, 1'b1, 3'd0);

      // all ports requesting, 1-flit packets
      i_request = 5'b11111;
      tick(); chk_state("rr0", 5'b00001, 1'b1, 3'd1);
      tick(); chk_state("rr1", 5'b00010, 1'b1, 3'd2);
      tick(); chk_state("rr2", 5'b00100, 1'b1, 3'd3);
      tick(); chk_state("rr3", 5'b01000, 1'b1, 3'd4);
      tick(); chk_state("rr4", 5'b10000, 1'b1, 3'd0);
      tick(); chk_state("rr5", 5'b00001, 1'b1, 3'd1);

      // only the current grantee requests again: re-granted, wrapping past empty ports
      i_request = 5'b00001;
      tick(); chk_state("self_regrant", 5'b00001, 1'b1, 3'd1);

      // tail with no requests returns to idle
      i_request = 5'b00000;
      tick(); chk_state("release", 5'b00000, 1'b0, 3'd1);

      // grantee drops its request mid-packet
      i_output_free = 1'b0;
      i_tail = 1'b0;
      i_request = 5'b00010;
      tick(); chk_state("p1_grant", 5'b00010, 1'b1, 3'd2);
      i_request = 5'b00000;
      tick(); chk("p1_stall", 8'(o_output_grant), 8'h02);
      i_output_free = 1'b1;
      tick(); chk("p1_body1", 8'(o_output_grant), 8'h02);
      tick(); chk("p1_body2", 8'(o_output_grant), 8'h02);
      i_tail = 1'b1;
      tick(); chk_state("p1_tail", 5'b00000, 1'b0, 3'd2);

      // free/tail pulses in idle are ignored
      tick(); chk_state("idle_tail", 5'b00000, 1'b0, 3'd2);
      i_output_free = 1'b0;
      i_tail = 1'b0;
      tick(); chk_state("idle_quiet", 5'b00000, 1'b0, 3'd2);

      // reset while busy on port 3
      i_request = 5'b01000;
      tick(); chk_state("p3_grant", 5'b01000, 1'b1, 3'd4);
      #2;
      rst = 1'b1;
      #1;
      chk_state("async_rst", 5'b00000, 1'b0, 3'd0);
      i_request = 5'b11111;
      tick();
      chk("rst_hold_grant", 8'(o_output_grant), 8'h00);
      rst = 1'b0;
      tick(); chk_state("post_rst", 5'b00001, 1'b1, 3'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
